// File: rtl/shiftreg_ring.sv
// Length-tracked shift chain with grow/pop shifting, a length-following tail tap,
// and a non-destructive rotation scan that streams the valid entries oldest-first.
module shiftreg_ring #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 234,
  parameter int unsigned LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             grow_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             scan_start_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] first_o,
  output logic [WIDTH-1:0] tail_o,
  output logic [LEN_W-1:0] len_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             shift_ready_o,
  output logic             scan_busy_o,
  output logic             scan_valid_o,
  output logic [WIDTH-1:0] scan_data_o,
  output logic             scan_done_o
);

  typedef enum logic {StIdle, StScan} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  logic             clr;
  logic             shift_en;
  logic [WIDTH-1:0] feed;
  logic [WIDTH-1:0] tail;
  logic             full;

  assign full = (len_q == LEN_W'(DEPTH));

  // Tail tap: oldest valid entry, zero when the chain is empty.
  always_comb begin
    tail = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (len_q == LEN_W'(k + 1)) tail = stage_q[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    shift_en = 1'b0;
    feed     = in_i;

    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          clr = 1'b1;
        end else if (shift_i) begin
          shift_en = 1'b1;
          if (grow_i && !full) len_d = len_q + LEN_W'(1);
        end else if (scan_start_i) begin
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StScan;
            idx_d   = '0;
          end
        end
      end
      StScan: begin
        if (clear_i) begin
          clr     = 1'b1;
          state_d = StIdle;
        end else begin
          // Rotate the tail back into the head; after len beats the body is restored.
          shift_en = 1'b1;
          feed     = tail;
          idx_d    = idx_q + LEN_W'(1);
          if (idx_q + LEN_W'(1) == len_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    stage_d = stage_q;
    if (clr) begin
      len_d = '0;
      for (int unsigned k = 0; k < DEPTH; k++) stage_d[k] = '0;
    end else if (shift_en) begin
      stage_d[0] = feed;
      for (int unsigned k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign out_o         = stage_q[DEPTH-1];
  assign first_o       = stage_q[1];
  assign tail_o        = tail;
  assign len_o         = len_q;
  assign empty_o       = (len_q == '0);
  assign full_o        = full;
  assign shift_ready_o = (state_q == StIdle);
  assign scan_busy_o   = (state_q == StScan);
  assign scan_valid_o  = (state_q == StScan);
  assign scan_data_o   = (state_q == StScan) ? tail : '0;
  assign scan_done_o   = done_q;

endmodule

// File: tb/tb_shiftreg_ring.sv
// Directed bench for shiftreg_ring at WIDTH=2, DEPTH=8 with hand-computed expectations.
module tb_shiftreg_ring;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LEN_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_i, shift_i, grow_i, scan_start_i;
  logic [WIDTH-1:0] in_i;
  logic [WIDTH-1:0] out_o, first_o, tail_o, scan_data_o;
  logic [LEN_W-1:0] len_o;
  logic             empty_o, full_o, shift_ready_o, scan_busy_o, scan_valid_o, scan_done_o;

  int checks = 0;
  int errors = 0;

  shiftreg_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .shift_i       (shift_i),
    .grow_i        (grow_i),
    .in_i          (in_i),
    .scan_start_i  (scan_start_i),
    .out_o         (out_o),
    .first_o       (first_o),
    .tail_o        (tail_o),
    .len_o         (len_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .shift_ready_o (shift_ready_o),
    .scan_busy_o   (scan_busy_o),
    .scan_valid_o  (scan_valid_o),
    .scan_data_o   (scan_data_o),
    .scan_done_o   (scan_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_shift(input logic g, input logic [WIDTH-1:0] d);
    shift_i = 1'b1;
    grow_i  = g;
    in_i    = d;
    tick();
    shift_i = 1'b0;
    grow_i  = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  logic [WIDTH-1:0] gv [9];

  initial begin
    gv = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0; clear_i = 1'b0; shift_i = 1'b0; grow_i = 1'b0;
    scan_start_i = 1'b0; in_i = '0;
    #12;
    chk("rst_len", len_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_ready", shift_ready_o, 1);
    chk("rst_busy", scan_busy_o, 0);
    chk("rst_valid", scan_valid_o, 0);
    chk("rst_done", scan_done_o, 0);
    chk("rst_tail", tail_o, 0);
    rst_n = 1'b1;

    // Grow to full, then one more grow shift saturates and drops the tail.
    for (int i = 0; i < 9; i++) begin
      do_shift(1'b1, gv[i]);
      chk("grow_len", len_o, (i < 8) ? i + 1 : 8);
    end
    chk("grow_full", full_o, 1);
    chk("grow_tail", tail_o, 2);
    chk("grow_first", first_o, 0);
    chk("grow_out", out_o, 2);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_len", len_o, 0);
    chk("arst_empty", empty_o, 1);
    chk("arst_full", full_o, 0);
    chk("arst_tail", tail_o, 0);
    chk("arst_out", out_o, 0);
    #1 rst_n = 1'b1;

    // Pop shift.
    do_shift(1'b1, 2'd1);
    do_shift(1'b1, 2'd2);
    do_shift(1'b1, 2'd3);
    chk("pre_pop_tail", tail_o, 1);
    do_shift(1'b0, 2'd0);
    chk("pop_len", len_o, 3);
    chk("pop_tail", tail_o, 2);
    chk("pop_first", first_o, 3);

    // Scan of [3,2,1]; a shift during the scan must be ignored.
    do_clear();
    chk("clr_len", len_o, 0);
    do_shift(1'b1, 2'd1);
    do_shift(1'b1, 2'd2);
    do_shift(1'b1, 2'd3);
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    chk("scan_busy", scan_busy_o, 1);
    chk("scan_ready", shift_ready_o, 0);
    chk("scan_v1", scan_valid_o, 1);
    chk("scan_d1", scan_data_o, 1);
    shift_i = 1'b1; grow_i = 1'b1; in_i = 2'd0;
    tick();
    shift_i = 1'b0; grow_i = 1'b0;
    chk("scan_v2", scan_valid_o, 1);
    chk("scan_d2", scan_data_o, 2);
    chk("scan_len", len_o, 3);
    tick();
    chk("scan_v3", scan_valid_o, 1);
    chk("scan_d3", scan_data_o, 3);
    tick();
    chk("scan_end_valid", scan_valid_o, 0);
    chk("scan_end_busy", scan_busy_o, 0);
    chk("scan_done", scan_done_o, 1);
    chk("scan_end_ready", shift_ready_o, 1);
    chk("scan_end_tail", tail_o, 1);
    chk("scan_end_first", first_o, 2);
    chk("scan_end_len", len_o, 3);
    tick();
    chk("scan_done_drop", scan_done_o, 0);

    // Scan with nothing stored.
    do_clear();
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    chk("scan0_busy", scan_busy_o, 0);
    chk("scan0_valid", scan_valid_o, 0);
    chk("scan0_done", scan_done_o, 1);
    tick();
    chk("scan0_done_drop", scan_done_o, 0);

    // Shift wins over a simultaneous scan request.
    do_shift(1'b1, 2'd1);
    do_shift(1'b1, 2'd2);
    do_shift(1'b1, 2'd3);
    shift_i = 1'b1; grow_i = 1'b1; in_i = 2'd0; scan_start_i = 1'b1;
    tick();
    shift_i = 1'b0; grow_i = 1'b0; scan_start_i = 1'b0;
    chk("ss_len", len_o, 4);
    chk("ss_busy", scan_busy_o, 0);
    chk("ss_first", first_o, 3);
    chk("ss_tail", tail_o, 1);
    tick();
    chk("ss_busy2", scan_busy_o, 0);
    chk("ss_done", scan_done_o, 0);

    // Clear during the second beat aborts without a done pulse.
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    chk("abort_d1", scan_data_o, 1);
    tick();
    chk("abort_d2", scan_data_o, 2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("abort_len", len_o, 0);
    chk("abort_busy", scan_busy_o, 0);
    chk("abort_done", scan_done_o, 0);
    chk("abort_empty", empty_o, 1);
    tick();
    chk("abort_done2", scan_done_o, 0);
    chk("abort_busy2", scan_busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
